// File: rtl/regfile_sb_if.sv
// ----------------------------------------------------------------------------
// regfile_sb_if
//   Bus bundle for the scoreboarded register file regfile_sb.
//
//   Parameters: XLEN (data width), NREGS (register count), NRD (read ports).
//
//   Signals (direction seen from the register file, i.e. the slave modport):
//     rd_addr      in   NRD*AW    read addresses, port k = [k*AW +: AW]
//     rd_data      out  NRD*XLEN  read data, port k = [k*XLEN +: XLEN]
//     rd_busy      out  NRD       busy bit of the register each port reads
//     wr_en        in   1         writeback strobe
//     wr_addr      in   AW        writeback destination
//     wr_data      in   XLEN      writeback data
//     iss_en       in   1         issue strobe, reserves iss_addr
//     iss_addr     in   AW        destination being reserved
//     clr_req      in   1         pulse that starts a full-file clear
//     clr_busy     out  1         clear sweep in progress
//     busy_vec     out  NREGS     whole scoreboard
//     debug_output out  XLEN      contents of the debug register
// ----------------------------------------------------------------------------
interface regfile_sb_if #(
    parameter int XLEN  = 64,
    parameter int NREGS = 32,
    parameter int NRD   = 2
);
    localparam int AW = $clog2(NREGS);

    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic                wr_en;
    logic [AW-1:0]       wr_addr;
    logic [XLEN-1:0]     wr_data;
    logic                iss_en;
    logic [AW-1:0]       iss_addr;
    logic                clr_req;
    logic                clr_busy;
    logic [NREGS-1:0]    busy_vec;
    logic [XLEN-1:0]     debug_output;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr, clr_req,
        input  rd_data, rd_busy, clr_busy, busy_vec, debug_output
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr, clr_req,
        output rd_data, rd_busy, clr_busy, busy_vec, debug_output
    );
endinterface

// File: rtl/regfile_sb.sv
// ----------------------------------------------------------------------------
// regfile_sb
//   Parametrised register file with combinational read ports, one writeback
//   port, a per-register busy scoreboard and a sequential clear engine.
//   Register 0 is hardwired to zero and is never busy.
//
//   Parameters: XLEN, NREGS (power of two, >= 4), NRD (1..4), DEBUG_REG.
//
//   Ports:
//     clk    in  clock, all state changes on the rising edge
//     rst_n  in  asynchronous active-low reset
//     bus    regfile_sb_if.slave (read ports, writeback, issue, clear, debug)
//
//   Build option:
//     REGFILE_BYPASS_EN  when defined, an accepted writeback is forwarded to
//                        any read port addressing the same register in the
//                        same cycle; otherwise reads show registered state.
// ----------------------------------------------------------------------------
module regfile_sb #(
    parameter int XLEN      = 64,
    parameter int NREGS     = 32,
    parameter int NRD       = 2,
    parameter int DEBUG_REG = NREGS - 1
) (
    input  logic        clk,
    input  logic        rst_n,
    regfile_sb_if.slave bus
);
    localparam int AW = $clog2(NREGS);

    typedef enum logic {IDLE, CLEAR} state_t;

    logic [XLEN-1:0]  mem_q [NREGS];
    logic [XLEN-1:0]  mem_d [NREGS];
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    state_t           state_q;
    logic [AW-1:0]    idx_q;
    logic             clr_busy_q;

    logic             wr_acc;
    logic             iss_acc;

    // Writes and issues are dropped outright while the sweep runs.
    assign wr_acc  = bus.wr_en  && (bus.wr_addr  != '0) && !clr_busy_q;
    assign iss_acc = bus.iss_en && (bus.iss_addr != '0) && !clr_busy_q;

    // Clear engine: walks idx from 1 to NREGS-1, one entry per cycle.
    // clr_busy is a registered copy of (state == CLEAR).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            clr_busy_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.clr_req) begin
                        state_q    <= CLEAR;
                        idx_q      <= AW'(1);
                        clr_busy_q <= 1'b1;
                    end
                end
                CLEAR: begin
                    idx_q <= idx_q + 1'b1;
                    if (idx_q == AW'(NREGS - 1)) begin
                        state_q    <= IDLE;
                        clr_busy_q <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    clr_busy_q <= 1'b0;
                end
            endcase
        end
    end

    // Next-state for storage and scoreboard. Issue is applied after
    // writeback so a same-cycle reservation of the written register wins.
    always_comb begin
        mem_d  = mem_q;
        busy_d = busy_q;
        if (clr_busy_q) begin
            mem_d[idx_q]  = '0;
            busy_d[idx_q] = 1'b0;
        end else begin
            if (wr_acc) begin
                mem_d[bus.wr_addr]  = bus.wr_data;
                busy_d[bus.wr_addr] = 1'b0;
            end
            if (iss_acc) begin
                busy_d[bus.iss_addr] = 1'b1;
            end
        end
        mem_d[0]  = '0;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                mem_q[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                mem_q[i] <= mem_d[i];
            end
            busy_q <= busy_d;
        end
    end

    // Combinational read ports.
    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]   ra;
        logic [XLEN-1:0] reg_val;

        assign ra      = bus.rd_addr[k*AW +: AW];
        assign reg_val = (ra == '0) ? '0 : mem_q[ra];

`ifdef REGFILE_BYPASS_EN
        logic hit;
        // wr_acc already excludes register 0, so x0 never forwards.
        assign hit = wr_acc && (bus.wr_addr == ra);
        assign bus.rd_data[k*XLEN +: XLEN] = hit ? bus.wr_data : reg_val;
        assign bus.rd_busy[k] = hit ? (iss_acc && (bus.iss_addr == ra))
                                    : busy_q[ra];
`else
        assign bus.rd_data[k*XLEN +: XLEN] = reg_val;
        assign bus.rd_busy[k]              = busy_q[ra];
`endif
    end

    assign bus.clr_busy     = clr_busy_q;
    assign bus.busy_vec     = busy_q;
    assign bus.debug_output = (DEBUG_REG == 0) ? '0 : mem_q[DEBUG_REG];

endmodule

// File: tb/tb_regfile_sb.sv
// ----------------------------------------------------------------------------
// tb_regfile_sb
//   Bench for regfile_sb: a default instance (XLEN=64, NREGS=32, NRD=2) and a
//   small instance (NREGS=16, NRD=3). Table vectors run through a scoreboard
//   queue; clear, bypass and reset corner cases are hand-written sequences.
// ----------------------------------------------------------------------------
module tb_regfile_sb;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk;
    logic rst_n;

    regfile_sb_if #(.XLEN(64), .NREGS(32), .NRD(2)) bus ();
    regfile_sb_if #(.XLEN(64), .NREGS(16), .NRD(3)) bus_s ();

    regfile_sb #(.XLEN(64), .NREGS(32), .NRD(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    regfile_sb #(.XLEN(64), .NREGS(16), .NRD(3)) dut_s (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        wr_en;
        logic [4:0]  wr_addr;
        logic [63:0] wr_data;
        logic        iss_en;
        logic [4:0]  iss_addr;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [63:0] exp_d0;
        logic [63:0] exp_d1;
        logic        exp_b0;
        logic        exp_b1;
        logic [31:0] exp_bv;
        logic [63:0] exp_dbg;
    } vec_t;

    typedef struct {
        logic [63:0] d0;
        logic [63:0] d1;
        logic        b0;
        logic        b1;
        logic [31:0] bv;
        logic [63:0] dbg;
    } exp_t;

    vec_t vecs[8];
    exp_t sb[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_rd(input int p, input logic [4:0] a);
        bus.rd_addr[p*5 +: 5] = a;
    endtask

    function automatic logic [63:0] rdd(input int p);
        return bus.rd_data[p*64 +: 64];
    endfunction

    task automatic wr(input logic [4:0] a, input logic [63:0] d);
        bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d;
        @(posedge clk); #1;
        bus.wr_en = 1'b0;
    endtask

    task automatic wr_s(input logic [3:0] a, input logic [63:0] d);
        bus_s.wr_en = 1'b1; bus_s.wr_addr = a; bus_s.wr_data = d;
        @(posedge clk); #1;
        bus_s.wr_en = 1'b0;
    endtask

    initial begin
        exp_t e;
        int   cnt;

        rst_n = 1'b1;
        bus.rd_addr = '0; bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.iss_en = 1'b0; bus.iss_addr = '0; bus.clr_req = 1'b0;
        bus_s.rd_addr = '0; bus_s.wr_en = 1'b0; bus_s.wr_addr = '0; bus_s.wr_data = '0;
        bus_s.iss_en = 1'b0; bus_s.iss_addr = '0; bus_s.clr_req = 1'b0;

        //                wr  waddr  wdata                   iss iaddr ra0 ra1  d0                      d1         b0 b1 bv            dbg
        vecs[0] = '{1'b1, 5'd0,  64'hDEAD,               1'b0, 5'd0,  5'd0,  5'd0,  64'h0,               64'h0,     1'b0, 1'b0, 32'h0,        64'h0};
        vecs[1] = '{1'b0, 5'd0,  64'h0,                  1'b1, 5'd5,  5'd5,  5'd5,  64'h0,               64'h0,     1'b1, 1'b1, 32'h20,       64'h0};
        vecs[2] = '{1'b1, 5'd5,  64'h1234,               1'b0, 5'd0,  5'd5,  5'd0,  64'h1234,            64'h0,     1'b0, 1'b0, 32'h0,        64'h0};
        vecs[3] = '{1'b1, 5'd7,  64'h55,                 1'b1, 5'd7,  5'd7,  5'd5,  64'h55,              64'h1234,  1'b1, 1'b0, 32'h80,       64'h0};
        vecs[4] = '{1'b1, 5'd7,  64'h77,                 1'b0, 5'd0,  5'd7,  5'd7,  64'h77,              64'h77,    1'b0, 1'b0, 32'h0,        64'h0};
        vecs[5] = '{1'b0, 5'd0,  64'h0,                  1'b1, 5'd31, 5'd31, 5'd7,  64'h0,               64'h77,    1'b1, 1'b0, 32'h8000_0000, 64'h0};
        vecs[6] = '{1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 5'd0,  5'd31, 5'd5,  64'hFFFF_FFFF_FFFF_FFFF, 64'h1234, 1'b0, 1'b0, 32'h0, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[7] = '{1'b0, 5'd0,  64'h0,                  1'b1, 5'd0,  5'd0,  5'd0,  64'h0,               64'h0,     1'b0, 1'b0, 32'h0,        64'hFFFF_FFFF_FFFF_FFFF};

        // Reset and check every address while held in reset and after.
        #2 rst_n = 1'b0;
        #1;
        check("rst clr_busy", bus.clr_busy, 0);
        check("rst busy_vec", bus.busy_vec, 0);
        check("rst debug", bus.debug_output, 0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        for (int a = 0; a < 32; a++) begin
            set_rd(0, 5'(a)); set_rd(1, 5'(31 - a));
            #1;
            check($sformatf("post-rst rd0 x%0d", a), rdd(0), 0);
            check($sformatf("post-rst rd1 x%0d", 31 - a), rdd(1), 0);
            check($sformatf("post-rst busy x%0d", a), bus.rd_busy, 0);
        end
        check("post-rst busy_vec", bus.busy_vec, 0);

        // Table vectors through the scoreboard.
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) begin
            bus.wr_en = vecs[i].wr_en; bus.wr_addr = vecs[i].wr_addr; bus.wr_data = vecs[i].wr_data;
            bus.iss_en = vecs[i].iss_en; bus.iss_addr = vecs[i].iss_addr;
            set_rd(0, vecs[i].ra0); set_rd(1, vecs[i].ra1);
            e.d0 = vecs[i].exp_d0; e.d1 = vecs[i].exp_d1;
            e.b0 = vecs[i].exp_b0; e.b1 = vecs[i].exp_b1;
            e.bv = vecs[i].exp_bv; e.dbg = vecs[i].exp_dbg;
            sb.push_back(e);
            @(posedge clk); #1;
            bus.wr_en = 1'b0; bus.iss_en = 1'b0;
            #1;
            e = sb.pop_front();
            check($sformatf("vec%0d rd0", i), rdd(0), e.d0);
            check($sformatf("vec%0d rd1", i), rdd(1), e.d1);
            check($sformatf("vec%0d busy0", i), bus.rd_busy[0], e.b0);
            check($sformatf("vec%0d busy1", i), bus.rd_busy[1], e.b1);
            check($sformatf("vec%0d busy_vec", i), bus.busy_vec, e.bv);
            check($sformatf("vec%0d debug", i), bus.debug_output, e.dbg);
        end
        check("scoreboard drained", sb.size(), 0);

        // Fill x1..x31 with their index, then run a clear.
        for (int a = 1; a < 32; a++) wr(5'(a), 64'(a));
        bus.clr_req = 1'b1;
        @(posedge clk); #1;
        bus.clr_req = 1'b0;
        cnt = 0;
        while (bus.clr_busy && cnt < 100) begin
            cnt++;
            bus.wr_en = 1'b0; bus.iss_en = 1'b0; bus.clr_req = 1'b0;
            if (cnt == 2) begin
                bus.wr_en = 1'b1; bus.wr_addr = 5'd3; bus.wr_data = 64'd9;
                bus.iss_en = 1'b1; bus.iss_addr = 5'd30;
            end
            if (cnt == 3) begin
                set_rd(0, 5'd3); #1;
                check("clear drops write x3", rdd(0), 64'd3);
                check("clear drops issue x30", bus.busy_vec, 0);
            end
            if (cnt == 6) begin
                set_rd(0, 5'd5); set_rd(1, 5'd6); #1;
                check("mid-clear swept x5", rdd(0), 0);
                check("mid-clear unswept x6", rdd(1), 64'd6);
            end
            if (cnt == 10) bus.clr_req = 1'b1;
            @(posedge clk); #1;
        end
        bus.clr_req = 1'b0;
        check("clr_busy cycles", cnt, 31);
        for (int a = 0; a < 32; a++) begin
            set_rd(0, 5'(a)); #1;
            check($sformatf("post-clear x%0d", a), rdd(0), 0);
        end
        check("post-clear busy_vec", bus.busy_vec, 0);
        check("post-clear debug", bus.debug_output, 0);
        wr(5'd3, 64'd9);
        set_rd(0, 5'd3); #1;
        check("write after clear", rdd(0), 64'd9);

        // Write-to-read forwarding.
        @(posedge clk); #1;
        set_rd(0, 5'd0); set_rd(1, 5'd4);
        bus.wr_en = 1'b1; bus.wr_addr = 5'd4; bus.wr_data = 64'hABCD;
        #1;
        check("bypass data", rdd(1), BYP ? 64'hABCD : 64'h0);
        check("bypass busy no issue", bus.rd_busy[1], 0);
        bus.iss_en = 1'b1; bus.iss_addr = 5'd4;
        #1;
        check("bypass busy with issue", bus.rd_busy[1], BYP ? 1 : 0);
        @(posedge clk); #1;
        bus.wr_en = 1'b0; bus.iss_en = 1'b0;
        #1;
        check("x4 after write+issue data", rdd(1), 64'hABCD);
        check("x4 after write+issue busy", bus.rd_busy[1], 1);
        bus.wr_en = 1'b1; bus.wr_addr = 5'd4; bus.wr_data = 64'h1111;
        #1;
        check("bypass hit clears busy", bus.rd_busy[1], BYP ? 0 : 1);
        @(posedge clk); #1;
        bus.wr_en = 1'b1; bus.wr_addr = 5'd0; bus.wr_data = 64'h5;
        #1;
        check("x0 never forwards", rdd(0), 0);
        @(posedge clk); #1;
        bus.wr_en = 1'b0;

        // Reset asserted mid-clear with a write pending.
        wr(5'd20, 64'h2020);
        wr(5'd31, 64'h3131);
        bus.iss_en = 1'b1; bus.iss_addr = 5'd12;
        @(posedge clk); #1;
        bus.iss_en = 1'b0;
        bus.clr_req = 1'b1;
        @(posedge clk); #1;
        bus.clr_req = 1'b0;
        @(posedge clk); #1;
        set_rd(0, 5'd20); set_rd(1, 5'd12);
        bus.wr_en = 1'b1; bus.wr_addr = 5'd25; bus.wr_data = 64'h77;
        #1;
        check("pre-rst x20", rdd(0), 64'h2020);
        check("pre-rst busy x12", bus.rd_busy[1], 1);
        check("pre-rst clr_busy", bus.clr_busy, 1);
        rst_n = 1'b0;
        #1;
        check("async rst rd0", rdd(0), 0);
        check("async rst busy", bus.rd_busy, 0);
        check("async rst busy_vec", bus.busy_vec, 0);
        check("async rst clr_busy", bus.clr_busy, 0);
        check("async rst debug", bus.debug_output, 0);
        bus.wr_en = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("after rst idle", bus.clr_busy, 0);
        set_rd(0, 5'd31); #1;
        check("after rst x31", rdd(0), 0);
        wr(5'd6, 64'h66);
        set_rd(0, 5'd6); #1;
        check("after rst write accepted", rdd(0), 64'h66);

        // Small configuration: NREGS=16, NRD=3.
        wr_s(4'd15, 64'hBEEF);
        wr_s(4'd1, 64'h1);
        bus_s.iss_en = 1'b1; bus_s.iss_addr = 4'd9;
        @(posedge clk); #1;
        bus_s.iss_en = 1'b0;
        bus_s.rd_addr = {4'd15, 4'd0, 4'd1};
        #1;
        check("s rd0 x1", bus_s.rd_data[0 +: 64], 64'h1);
        check("s rd1 x0", bus_s.rd_data[64 +: 64], 0);
        check("s rd2 x15", bus_s.rd_data[128 +: 64], 64'hBEEF);
        check("s debug x15", bus_s.debug_output, 64'hBEEF);
        bus_s.rd_addr = {4'd9, 4'd0, 4'd1};
        #1;
        check("s busy x9", bus_s.rd_busy, 3'b100);
        bus_s.clr_req = 1'b1;
        @(posedge clk); #1;
        bus_s.clr_req = 1'b0;
        cnt = 0;
        while (bus_s.clr_busy && cnt < 100) begin
            cnt++;
            @(posedge clk); #1;
        end
        check("s clr_busy cycles", cnt, 15);
        bus_s.rd_addr = {4'd15, 4'd9, 4'd1};
        #1;
        check("s post-clear rd0", bus_s.rd_data[0 +: 64], 0);
        check("s post-clear rd2", bus_s.rd_data[128 +: 64], 0);
        check("s post-clear busy_vec", bus_s.busy_vec, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
